waveform_analyzer: RTL



---
 rtl/waveform_analyzer_pkg.sv | 22 ++
 rtl/waveform_analyzer_crossing.sv | 44 ++++
 rtl/waveform_analyzer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/waveform_analyzer_pkg.sv
// Shared definitions for the waveform analyzer and the generator benches.
// Holds the FSM state encoding and the default crossing threshold/hysteresis.
// No ports; imported with "import waveform_analyzer_pkg::*;".
package waveform_analyzer_pkg;

  // Analyzer state: waiting for the first rising crossing, or measuring a period.
  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  // Default crossing midpoint and hysteresis half-width (unsigned 8-bit domain).
  localparam int DEF_THRESH = 128;
  localparam int DEF_HYST   = 8;

  // Schmitt trigger output level.
  typedef enum logic {
    LVL_LOW  = 1'b0,
    LVL_HIGH = 1'b1
  } level_t;

endpackage

// File: rtl/waveform_analyzer_crossing.sv
// Schmitt-trigger rising-crossing detector for 8-bit unsigned samples.
// Ports: clk, rst (sync active-low), sample_valid/sample in; level (registered
// hysteresis state) and rise (combinational, asserted on the accepted sample that flips LOW->HIGH).
module schmitt_crossing_detector
  import waveform_analyzer_pkg::*;
#(
  parameter int THRESH = DEF_THRESH,
  parameter int HYST   = DEF_HYST
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_valid,
  input  logic [7:0] sample,
  output level_t     level,
  output logic       rise
);

  // Compare in 9 bits so THRESH+HYST up to 255 and THRESH-HYST down to 0 stay exact.
  localparam logic [8:0] HI_LVL = 9'(THRESH + HYST);
  localparam logic [8:0] LO_LVL = 9'(THRESH - HYST);

  logic [8:0] sample_ext;
  logic       at_high;
  logic       at_low;

  assign sample_ext = {1'b0, sample};
  assign at_high    = (sample_ext >= HI_LVL);
  assign at_low     = (sample_ext <= LO_LVL);

  assign rise = sample_valid && (level == LVL_LOW) && at_high;

  always_ff @(posedge clk) begin
    if (!rst) begin
      level <= LVL_LOW;
    end else if (sample_valid) begin
      if (level == LVL_LOW && at_high) begin
        level <= LVL_HIGH;
      end else if (level == LVL_HIGH && at_low) begin
        level <= LVL_LOW;
      end
    end
  end

endmodule

// File: rtl/waveform_analyzer.sv
// Measures period, min, max and peak-to-peak amplitude between rising threshold
// crossings of an 8-bit sample stream; times out after MAX_PERIOD samples without a crossing.
// Ports: clk, rst (sync active-low), sample_valid/sample in; period/min_val/max_val/amplitude
// results with result_valid pulse, timeout pulse, locked level. Results appear one cycle after the crossing sample.
module waveform_analyzer
  import waveform_analyzer_pkg::*;
#(
  parameter int THRESH     = DEF_THRESH,
  parameter int HYST       = DEF_HYST,
  parameter int PERIOD_W   = 16,
  parameter int MAX_PERIOD = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_valid,
  input  logic [7:0]          sample,
  output logic [PERIOD_W-1:0] period,
  output logic [7:0]          min_val,
  output logic [7:0]          max_val,
  output logic [7:0]          amplitude,
  output logic                result_valid,
  output logic                timeout,
  output logic                locked
);

  localparam logic [PERIOD_W-1:0] MAX_CNT = PERIOD_W'(MAX_PERIOD);
  localparam logic [PERIOD_W-1:0] ONE     = PERIOD_W'(1);

  level_t level;
  logic   rise;

  schmitt_crossing_detector #(
    .THRESH (THRESH),
    .HYST   (HYST)
  ) u_crossing (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample       (sample),
    .level        (level),
    .rise         (rise)
  );

  state_t              state, state_nxt;
  logic [PERIOD_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic [7:0]          min_r, min_nxt;
  logic [7:0]          max_r, max_nxt;
  logic [PERIOD_W-1:0] period_nxt;
  logic [7:0]          min_val_nxt, max_val_nxt, amplitude_nxt;
  logic                result_valid_nxt, timeout_nxt;

  assign cnt_inc = cnt + ONE;
  assign locked  = (state == MEASURE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      min_r        <= 8'hFF;
      max_r        <= 8'h00;
      period       <= '0;
      min_val      <= 8'h00;
      max_val      <= 8'h00;
      amplitude    <= 8'h00;
      result_valid <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      min_r        <= min_nxt;
      max_r        <= max_nxt;
      period       <= period_nxt;
      min_val      <= min_val_nxt;
      max_val      <= max_val_nxt;
      amplitude    <= amplitude_nxt;
      result_valid <= result_valid_nxt;
      timeout      <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    cnt_nxt          = cnt;
    min_nxt          = min_r;
    max_nxt          = max_r;
    period_nxt       = period;
    min_val_nxt      = min_val;
    max_val_nxt      = max_val;
    amplitude_nxt    = amplitude;
    result_valid_nxt = 1'b0;
    timeout_nxt      = 1'b0;

    if (sample_valid) begin
      case (state)
        IDLE: begin
          if (rise) begin
            state_nxt = MEASURE;
            cnt_nxt   = ONE;
            min_nxt   = sample;
            max_nxt   = sample;
          end
        end
        MEASURE: begin
          if (rise) begin
            // The crossing sample closes the old period and opens the new one.
            period_nxt       = cnt;
            min_val_nxt      = min_r;
            max_val_nxt      = max_r;
            amplitude_nxt    = max_r - min_r;
            result_valid_nxt = 1'b1;
            cnt_nxt          = ONE;
            min_nxt          = sample;
            max_nxt          = sample;
          end else if (cnt_inc == MAX_CNT) begin
            // Too long without a crossing: drop the partial period, keep old results.
            timeout_nxt = 1'b1;
            state_nxt   = IDLE;
            cnt_nxt     = '0;
            min_nxt     = 8'hFF;
            max_nxt     = 8'h00;
          end else begin
            cnt_nxt = cnt_inc;
            if (sample < min_r) min_nxt = sample;
            if (sample > max_r) max_nxt = sample;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

endmodule
